// File: rtl/cmp_tracker.sv
// cmp_tracker: registered magnitude comparator with running max/min tracking.
//
// Each accepted sample (in_valid=1, clear=0) is compared a-vs-b in its own
// signed/unsigned mode, and the result appears one cycle later. The stream of
// a values is also tracked: running max, running min and a saturating count,
// all in the mode latched by the first tracked sample.
//
// Optional feature macro: CMP_GTCNT_EN adds the gt_cnt port and its
// saturating counter of gt results.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing tracked since reset/clear; next sample seeds max/min
// ST_TRACK | tracking active; samples in the latched mode update max/min

module cmp_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             tracking,
  output logic             mode_err,
  output logic [CNT_W-1:0] sample_cnt
`ifdef CMP_GTCNT_EN
  ,
  output logic [CNT_W-1:0] gt_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Flipping the MSB maps two's-complement order onto unsigned order.
  function automatic logic less_than(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic sgn);
    logic [WIDTH-1:0] flip;
    flip = sgn ? MSB_BIT : '0;
    return (x ^ flip) < (y ^ flip);
  endfunction

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             trk_signed_q, trk_signed_d;
  logic             mode_err_q, mode_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmp_gt;

  // Signed-aware a>b for the current sample; also feeds the optional gt counter.
  always_comb begin
    cmp_gt = less_than(b, a, signed_mode);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state plus compare-result and tracking datapath updates.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    gt_d         = gt_q;
    eq_d         = eq_q;
    lt_d         = lt_q;
    max_d        = max_q;
    min_d        = min_q;
    trk_signed_d = trk_signed_q;
    mode_err_d   = mode_err_q;
    cnt_d        = cnt_q;

    if (clear) begin
      // Clear wins over a coincident sample; compare flags keep their last value.
      state_d      = ST_EMPTY;
      max_d        = '0;
      min_d        = '0;
      trk_signed_d = 1'b0;
      mode_err_d   = 1'b0;
      cnt_d        = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      gt_d        = cmp_gt;
      lt_d        = less_than(a, b, signed_mode);
      eq_d        = (a == b);
      case (state_q)
        ST_EMPTY: begin
          state_d      = ST_TRACK;
          max_d        = a;
          min_d        = a;
          trk_signed_d = signed_mode;
          cnt_d        = CNT_W'(1);
        end
        ST_TRACK: begin
          if (signed_mode == trk_signed_q) begin
            if (less_than(max_q, a, trk_signed_q)) max_d = a;
            if (less_than(a, min_q, trk_signed_q)) min_d = a;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            mode_err_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      gt_q         <= 1'b0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
      max_q        <= '0;
      min_q        <= '0;
      trk_signed_q <= 1'b0;
      mode_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      gt_q         <= gt_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
      max_q        <= max_d;
      min_q        <= min_d;
      trk_signed_q <= trk_signed_d;
      mode_err_q   <= mode_err_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef CMP_GTCNT_EN
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

  // Counts every accepted gt result, independent of tracking state or mode.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    if (clear) gt_cnt_d = '0;
    else if (in_valid && cmp_gt && (gt_cnt_q != CNT_MAX)) gt_cnt_d = gt_cnt_q + CNT_W'(1);
  end

  // gt counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gt_cnt_q <= '0;
    else        gt_cnt_q <= gt_cnt_d;
  end

  assign gt_cnt = gt_cnt_q;
`endif

  assign out_valid  = out_valid_q;
  assign gt         = gt_q;
  assign eq         = eq_q;
  assign lt         = lt_q;
  assign max_val    = max_q;
  assign min_val    = min_q;
  assign tracking   = (state_q == ST_TRACK);
  assign mode_err   = mode_err_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_tracker.sv
// Testbench for cmp_tracker: two instances (CNT_W=8 and CNT_W=2) share all
// inputs; outputs are checked against a queue-based reference model.
module tb_cmp_tracker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       signed_mode;
  logic       clear;
  logic [3:0] a;
  logic [3:0] b;

  logic       ov1, gt1, eq1, lt1, trk1, err1;
  logic [3:0] max1, min1;
  logic [7:0] cnt1;
  logic       ov2, gt2, eq2, lt2, trk2, err2;
  logic [3:0] max2, min2;
  logic [1:0] cnt2;
`ifdef CMP_GTCNT_EN
  logic [7:0] gtc1;
  logic [1:0] gtc2;
`endif

  cmp_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .clear(clear), .a(a), .b(b), .out_valid(ov1), .gt(gt1), .eq(eq1), .lt(lt1),
    .max_val(max1), .min_val(min1), .tracking(trk1), .mode_err(err1),
    .sample_cnt(cnt1)
`ifdef CMP_GTCNT_EN
    , .gt_cnt(gtc1)
`endif
  );

  cmp_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .clear(clear), .a(a), .b(b), .out_valid(ov2), .gt(gt2), .eq(eq2), .lt(lt2),
    .max_val(max2), .min_val(min2), .tracking(trk2), .mode_err(err2),
    .sample_cnt(cnt2)
`ifdef CMP_GTCNT_EN
    , .gt_cnt(gtc2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: list of tracked a values plus flags.
  logic [3:0] trk_q[$];
  logic       m_track, m_sgn, m_err, m_ov, m_gt, m_eq, m_lt;
  int         m_gtc;

  function automatic int sval(input logic [3:0] x, input logic s);
    return s ? int'($signed(x)) : int'(x);
  endfunction

  function automatic logic [3:0] exp_max();
    logic [3:0] best;
    if (trk_q.size() == 0) return 4'h0;
    best = trk_q[0];
    foreach (trk_q[i]) if (sval(trk_q[i], m_sgn) > sval(best, m_sgn)) best = trk_q[i];
    return best;
  endfunction

  function automatic logic [3:0] exp_min();
    logic [3:0] best;
    if (trk_q.size() == 0) return 4'h0;
    best = trk_q[0];
    foreach (trk_q[i]) if (sval(trk_q[i], m_sgn) < sval(best, m_sgn)) best = trk_q[i];
    return best;
  endfunction

  function automatic int sat(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    trk_q.delete();
    m_track = 0; m_sgn = 0; m_err = 0; m_ov = 0;
    m_gt = 0; m_eq = 0; m_lt = 0; m_gtc = 0;
  endtask

  task automatic model_apply(input logic iv, input logic sm, input logic clr,
                             input logic [3:0] av, input logic [3:0] bv);
    int sa, sb;
    if (clr) begin
      trk_q.delete();
      m_track = 0; m_sgn = 0; m_err = 0; m_ov = 0; m_gtc = 0;
    end else if (iv) begin
      sa = sval(av, sm);
      sb = sval(bv, sm);
      m_ov = 1;
      m_gt = (sa > sb); m_eq = (sa == sb); m_lt = (sa < sb);
      if (m_gt) m_gtc++;
      if (!m_track) begin
        m_track = 1; m_sgn = sm; trk_q.push_back(av);
      end else if (sm == m_sgn) begin
        trk_q.push_back(av);
      end else begin
        m_err = 1;
      end
    end else begin
      m_ov = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it in, then advance the model.
  task automatic drive(input logic iv, input logic sm, input logic clr,
                       input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = iv; signed_mode = sm; clear = clr; a = av; b = bv;
    @(posedge clk);
    #1;
    model_apply(iv, sm, clr, av, bv);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; signed_mode = 0; clear = 0; a = 0; b = 0;
    model_reset();
    #2;
    total++; if ({ov1, gt1, eq1, lt1, trk1, err1} !== 6'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=000000", {ov1, gt1, eq1, lt1, trk1, err1}); end
    total++; if ({max1, min1, cnt1} !== 16'h0) begin bad++;
      $display("FAIL reset_vals got=%h exp=0000", {max1, min1, cnt1}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_signed_unsigned();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0111);
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b1100) begin bad++;
      $display("FAIL unsigned_cmp got=%b exp=1100", {ov1, gt1, eq1, lt1}); end
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 4'b0111);
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b1001) begin bad++;
      $display("FAIL signed_cmp got=%b exp=1001", {ov1, gt1, eq1, lt1}); end
  endtask

  task automatic test_track_unsigned();
    logic [3:0] seq[4] = '{4'd5, 4'd2, 4'd9, 4'd9};
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    foreach (seq[i]) drive(1'b1, 1'b0, 1'b0, seq[i], 4'd4);
    total++; if ({max1, min1, cnt1} !== {4'd9, 4'd2, 8'd4}) begin bad++;
      $display("FAIL track_unsigned got max=%0d min=%0d cnt=%0d exp max=9 min=2 cnt=4", max1, min1, cnt1); end
    total++; if (eq1 !== 1'b0 || gt1 !== 1'b1) begin bad++;
      $display("FAIL track_unsigned_cmp got gt=%b eq=%b exp gt=1 eq=0", gt1, eq1); end
  endtask

  task automatic test_track_signed();
    logic [3:0] seq[3] = '{4'hF, 4'h3, 4'h8};
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    foreach (seq[i]) drive(1'b1, 1'b1, 1'b0, seq[i], 4'h0);
    total++; if ({max1, min1, cnt1} !== {4'h3, 4'h8, 8'd3}) begin bad++;
      $display("FAIL track_signed got max=%h min=%h cnt=%0d exp max=3 min=8 cnt=3", max1, min1, cnt1); end
    total++; if (trk1 !== 1'b1 || err1 !== 1'b0) begin bad++;
      $display("FAIL track_signed_flags got trk=%b err=%b exp trk=1 err=0", trk1, err1); end
  endtask

  task automatic test_mode_mismatch();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h5, 4'h5);
    drive(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
    total++; if ({err1, max1, min1, cnt1} !== {1'b1, 4'h5, 4'h5, 8'd1}) begin bad++;
      $display("FAIL mismatch_track got err=%b max=%h min=%h cnt=%0d exp err=1 max=5 min=5 cnt=1", err1, max1, min1, cnt1); end
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b1001) begin bad++;
      $display("FAIL mismatch_cmp got=%b exp=1001", {ov1, gt1, eq1, lt1}); end
    drive(1'b1, 1'b0, 1'b0, 4'h1, 4'h2);
    total++; if ({err1, min1, cnt1} !== {1'b1, 4'h1, 8'd2}) begin bad++;
      $display("FAIL mismatch_sticky got err=%b min=%h cnt=%0d exp err=1 min=1 cnt=2", err1, min1, cnt1); end
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 1'b0, 1'b0, 4'h7, 4'h1);
    drive(1'b1, 1'b0, 1'b1, 4'h2, 4'h9);
    total++; if ({ov1, trk1, err1} !== 3'b000 || cnt1 !== 8'd0 || max1 !== 4'h0) begin bad++;
      $display("FAIL clear_collision got ov=%b trk=%b err=%b cnt=%0d max=%h exp all 0", ov1, trk1, err1, cnt1, max1); end
    total++; if ({gt1, eq1, lt1} !== 3'b100) begin bad++;
      $display("FAIL clear_hold_cmp got=%b exp=100", {gt1, eq1, lt1}); end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 4'(i + 5), 4'h1);
    total++; if (cnt2 !== 2'd3) begin bad++;
      $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
    total++; if (cnt1 !== 8'd5 || max2 !== 4'h9 || min2 !== 4'h5) begin bad++;
      $display("FAIL sat_cnt1 got cnt=%0d max2=%h min2=%h exp cnt=5 max2=9 min2=5", cnt1, max2, min2); end
`ifdef CMP_GTCNT_EN
    total++; if (gtc2 !== 2'd3 || gtc1 !== 8'd5) begin bad++;
      $display("FAIL gt_cnt_sat got gtc2=%0d gtc1=%0d exp gtc2=3 gtc1=5", gtc2, gtc1); end
    drive(1'b1, 1'b0, 1'b1, 4'h9, 4'h1);
    total++; if (gtc1 !== 8'd0 || gtc2 !== 2'd0) begin bad++;
      $display("FAIL gt_cnt_clear got gtc1=%0d gtc2=%0d exp 0", gtc1, gtc2); end
`endif
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h3, 4'h3);
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b1010) begin bad++;
      $display("FAIL b2b_first got=%b exp=1010", {ov1, gt1, eq1, lt1}); end
    drive(1'b1, 1'b0, 1'b0, 4'h2, 4'hA);
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b1001) begin bad++;
      $display("FAIL b2b_second got=%b exp=1001", {ov1, gt1, eq1, lt1}); end
    idle();
    total++; if ({ov1, gt1, eq1, lt1} !== 4'b0001) begin bad++;
      $display("FAIL idle_hold got=%b exp=0001", {ov1, gt1, eq1, lt1}); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 4'hC, 4'h1);
    @(negedge clk);
    in_valid = 1'b1; a = 4'hD; b = 4'h2;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    total++; if ({ov1, gt1, eq1, lt1, trk1, err1, max1, min1, cnt1} !== 22'h0) begin bad++;
      $display("FAIL reset_mid got ov=%b gt=%b trk=%b max=%h min=%h cnt=%0d exp all 0", ov1, gt1, trk1, max1, min1, cnt1); end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'hE, 4'h1);
    total++; if ({trk1, max1, min1, cnt1} !== {1'b1, 4'hE, 4'hE, 8'd1}) begin bad++;
      $display("FAIL reset_first got trk=%b max=%h min=%h cnt=%0d exp trk=1 max=e min=e cnt=1", trk1, max1, min1, cnt1); end
  endtask

  task automatic test_random();
    logic sm;
    sm = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sm = ~sm;
      drive(($urandom_range(0, 3) != 0), sm, ($urandom_range(0, 24) == 0),
            4'($urandom), 4'($urandom));
      total++; if ({ov1, gt1, eq1, lt1} !== {m_ov, m_gt, m_eq, m_lt}) begin bad++;
        $display("FAIL rnd_cmp i=%0d got=%b exp=%b", i, {ov1, gt1, eq1, lt1}, {m_ov, m_gt, m_eq, m_lt}); end
      total++; if ({trk1, err1, max1, min1} !== {m_track, m_err, exp_max(), exp_min()}) begin bad++;
        $display("FAIL rnd_track i=%0d got trk=%b err=%b max=%h min=%h exp trk=%b err=%b max=%h min=%h",
                 i, trk1, err1, max1, min1, m_track, m_err, exp_max(), exp_min()); end
      total++; if (int'(cnt1) != sat(trk_q.size(), 255) || int'(cnt2) != sat(trk_q.size(), 3)) begin bad++;
        $display("FAIL rnd_cnt i=%0d got cnt1=%0d cnt2=%0d exp cnt1=%0d cnt2=%0d",
                 i, cnt1, cnt2, sat(trk_q.size(), 255), sat(trk_q.size(), 3)); end
`ifdef CMP_GTCNT_EN
      total++; if (int'(gtc1) != sat(m_gtc, 255) || int'(gtc2) != sat(m_gtc, 3)) begin bad++;
        $display("FAIL rnd_gtcnt i=%0d got gtc1=%0d gtc2=%0d exp %0d/%0d",
                 i, gtc1, gtc2, sat(m_gtc, 255), sat(m_gtc, 3)); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_track_unsigned();
    test_track_signed();
    test_mode_mismatch();
    test_clear_collision();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
